// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers and the per-stage {valid, tag} record used by the adder-tree family.
package adder_tree_pkg;

    // Tags narrower than this are zero-padded inside the stage record.
    localparam int unsigned TAG_W_MAX = 32;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
    } stage_meta_t;

    function automatic int unsigned lanes(input int unsigned levels);
        return 32'd1 << levels;
    endfunction

    function automatic int unsigned out_width(input int unsigned width, input int unsigned levels);
        return width + levels;
    endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Producer/consumer bus of the pipelined adder tree: lane-parallel input stream and single-sum output stream.
interface pipelined_adder_tree_if #(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned LEVELS = 3,
    parameter int unsigned TAG_W  = 4
);
    import adder_tree_pkg::*;

    localparam int unsigned N     = lanes(LEVELS);
    localparam int unsigned OUT_W = out_width(WIDTH, LEVELS);

    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_sum;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_tag
    );

endinterface

// File: rtl/adder_tree_level.sv
// One tree level: PAIRS extend-and-add units feeding a load-enabled stage register with valid/tag.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int unsigned IN_W   = 17,
    parameter int unsigned PAIRS  = 4,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        load_i,
    input  stage_meta_t                 meta_i,
    input  logic [2*PAIRS*IN_W-1:0]     data_i,
    output stage_meta_t                 meta_o,
    output logic [PAIRS*(IN_W+1)-1:0]   data_o
);

    localparam int unsigned SUM_W = IN_W + 1;
    localparam logic [TAG_W_MAX-1:0] TAG_MASK = {TAG_W_MAX{1'b1}} >> (TAG_W_MAX - TAG_W);

    logic [PAIRS*SUM_W-1:0] sum_w;

    for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
        logic [IN_W-1:0]  a_w;
        logic [IN_W-1:0]  b_w;
        logic [SUM_W-1:0] a_ext;
        logic [SUM_W-1:0] b_ext;

        assign a_w   = data_i[(2*gi)*IN_W +: IN_W];
        assign b_w   = data_i[(2*gi+1)*IN_W +: IN_W];
        // One guard bit per level is exactly enough for the pairwise sum to never overflow.
        assign a_ext = {SIGNED & a_w[IN_W-1], a_w};
        assign b_ext = {SIGNED & b_w[IN_W-1], b_w};
        assign sum_w[gi*SUM_W +: SUM_W] = a_ext + b_ext;
    end

    stage_meta_t              meta_q;
    stage_meta_t              meta_d;
    logic [PAIRS*SUM_W-1:0]   data_q;
    logic [PAIRS*SUM_W-1:0]   data_d;

    always_comb begin
        meta_d = meta_q;
        data_d = data_q;
        if (load_i) begin
            meta_d.valid = meta_i.valid;
            meta_d.tag   = meta_i.tag & TAG_MASK;
            data_d       = sum_w;
        end
        if (flush) begin
            meta_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            data_q <= '0;
        end else begin
            meta_q <= meta_d;
            data_q <= data_d;
        end
    end

    assign meta_o = meta_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined binary adder tree: 2**LEVELS lanes reduced to one exact sum, with valid/ready backpressure.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned LEVELS = 3,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    pipelined_adder_tree_if.slave  bus
);

    localparam int unsigned N     = lanes(LEVELS);
    localparam int unsigned OUT_W = out_width(WIDTH, LEVELS);

    logic [LEVELS:0]   v_w;
    logic [LEVELS+1:0] adv_c;
    logic              accept_w;

    // A stage may load when it is empty or its content moves on this cycle, so bubbles collapse.
    always_comb begin
        adv_c           = '0;
        adv_c[LEVELS+1] = bus.out_ready;
        for (int k = int'(LEVELS); k >= 0; k--) begin
            adv_c[k] = !v_w[k] || adv_c[k+1];
        end
    end

    assign bus.in_ready = adv_c[0];
    assign accept_w     = bus.in_valid && adv_c[0];

    stage_meta_t          s0_meta_q;
    stage_meta_t          s0_meta_d;
    logic [N*WIDTH-1:0]   s0_data_q;
    logic [N*WIDTH-1:0]   s0_data_d;

    always_comb begin
        s0_meta_d = s0_meta_q;
        s0_data_d = s0_data_q;
        if (adv_c[0]) begin
            s0_meta_d.valid = accept_w;
            s0_meta_d.tag   = TAG_W_MAX'(bus.in_tag);
            s0_data_d       = bus.in_data;
        end
        if (flush) begin
            s0_meta_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_meta_q <= '0;
            s0_data_q <= '0;
        end else begin
            s0_meta_q <= s0_meta_d;
            s0_data_q <= s0_data_d;
        end
    end

    for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_stage
        localparam int unsigned DW = (gi == 0) ? N * WIDTH : (N >> gi) * (WIDTH + gi);

        stage_meta_t   meta_w;
        logic [DW-1:0] data_w;

        if (gi == 0) begin : g_s0
            assign meta_w = s0_meta_q;
            assign data_w = s0_data_q;
        end else begin : g_lvl
            adder_tree_level #(
                .IN_W   (WIDTH + gi - 1),
                .PAIRS  (N >> gi),
                .SIGNED (SIGNED),
                .TAG_W  (TAG_W)
            ) u_level (
                .clk    (clk),
                .rst_n  (rst_n),
                .flush  (flush),
                .load_i (adv_c[gi]),
                .meta_i (g_stage[gi-1].meta_w),
                .data_i (g_stage[gi-1].data_w),
                .meta_o (meta_w),
                .data_o (data_w)
            );
        end

        assign v_w[gi] = meta_w.valid;
    end

    assign bus.out_valid = g_stage[LEVELS].meta_w.valid;
    assign bus.out_sum   = OUT_W'(g_stage[LEVELS].data_w);
    assign bus.out_tag   = g_stage[LEVELS].meta_w.tag[TAG_W-1:0];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for the pipelined adder tree: unsigned/signed 8-lane trees and a 2-lane tree, scoreboard checked.
module tb_pipelined_adder_tree;

    typedef struct {
        logic [19:0] sum;
        logic [3:0]  tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder_tree_if #(.WIDTH(17), .LEVELS(3), .TAG_W(4)) if0 ();
    pipelined_adder_tree_if #(.WIDTH(17), .LEVELS(3), .TAG_W(4)) if1 ();
    pipelined_adder_tree_if #(.WIDTH(17), .LEVELS(1), .TAG_W(4)) if2 ();

    pipelined_adder_tree #(.WIDTH(17), .LEVELS(3), .SIGNED(1'b0), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0));
    pipelined_adder_tree #(.WIDTH(17), .LEVELS(3), .SIGNED(1'b1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1));
    pipelined_adder_tree #(.WIDTH(17), .LEVELS(1), .SIGNED(1'b0), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t         sbq[3][$];
    int           pops[3];
    int           mark[3];
    int           first_pop[3];
    int           last_pop[3];
    logic         acc_last[3];
    logic [135:0] din[3];
    logic [3:0]   tin[3];
    logic         vin[3];
    logic         rdy[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic get_ov(input int d);
        case (d)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic [19:0] get_sum(input int d);
        case (d)
            0:       return if0.out_sum;
            1:       return if1.out_sum;
            default: return {2'b00, if2.out_sum};
        endcase
    endfunction

    function automatic logic [3:0] get_tag(input int d);
        case (d)
            0:       return if0.out_tag;
            1:       return if1.out_tag;
            default: return if2.out_tag;
        endcase
    endfunction

    // Reference sum: dut0 8 unsigned lanes, dut1 8 signed lanes, dut2 2 unsigned lanes.
    function automatic logic [19:0] model(input int d, input logic [135:0] data);
        longint acc = 0;
        longint lane;
        int     n = (d == 2) ? 2 : 8;
        for (int i = 0; i < n; i++) begin
            lane = longint'(data[i*17 +: 17]);
            if (d == 1 && lane >= 65536) lane = lane - 131072;
            acc = acc + lane;
        end
        return acc[19:0];
    endfunction

    function automatic logic [135:0] fill(input int n, input logic [16:0] val);
        logic [135:0] r = '0;
        for (int i = 0; i < n; i++) r[i*17 +: 17] = val;
        return r;
    endfunction

    function automatic logic [135:0] rand_vec();
        logic [135:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*17 +: 17] = 17'($urandom);
        return r;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [135:0] data, input logic [3:0] tag);
        vin[d] = v;
        din[d] = data;
        tin[d] = tag;
        case (d)
            0: begin if0.in_valid = v; if0.in_data = data;        if0.in_tag = tag; end
            1: begin if1.in_valid = v; if1.in_data = data;        if1.in_tag = tag; end
            default: begin if2.in_valid = v; if2.in_data = data[33:0]; if2.in_tag = tag; end
        endcase
    endtask

    task automatic set_rdy(input int d, input logic r);
        rdy[d] = r;
        case (d)
            0:       if0.out_ready = r;
            1:       if1.out_ready = r;
            default: if2.out_ready = r;
        endcase
    endtask

    // One clock: check/pop outputs at the falling edge, then push accepted vectors at the rising edge.
    task automatic tick();
        logic a[3];
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            a[d] = 1'b0;
            if (rst_n) begin
                if (get_ov(d)) begin
                    chk($sformatf("out_expected_dut%0d", d), 32'(sbq[d].size() != 0), 32'd1);
                    if (sbq[d].size() != 0) begin
                        chk($sformatf("out_sum_dut%0d", d), 32'(get_sum(d)), 32'(sbq[d][0].sum));
                        chk($sformatf("out_tag_dut%0d", d), 32'(get_tag(d)), 32'(sbq[d][0].tag));
                        if (rdy[d]) begin
                            $display("OUT dut%0d tag %h sum %h cycle %0d", d, get_tag(d), get_sum(d), cyc);
                            sbq[d].delete(0);
                            pops[d]++;
                            if (pops[d] == mark[d] + 1) first_pop[d] = cyc;
                            last_pop[d] = cyc;
                        end
                    end
                end
                a[d] = vin[d] && get_ir(d);
            end
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 3; d++) begin
            acc_last[d] = a[d];
            if (flush) sbq[d].delete();
            else if (a[d]) sbq[d].push_back('{model(d, din[d]), tin[d]});
        end
        #1;
    endtask

    task automatic wait_out(input int d);
        int n = 0;
        while (!get_ov(d) && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("wait_out_dut%0d", d), 32'(get_ov(d)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            pops[d] = 0; mark[d] = 0; first_pop[d] = 0; last_pop[d] = 0; acc_last[d] = 1'b0;
            set_in(d, 1'b0, '0, 4'h0);
            set_rdy(d, 1'b1);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid0", 32'(if0.out_valid), 32'd0);
        chk("rst_out_sum0",   32'(if0.out_sum),   32'd0);
        chk("rst_out_tag0",   32'(if0.out_tag),   32'd0);
        chk("rst_out_valid2", 32'(if2.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) chk($sformatf("rst_in_ready%0d", d), 32'(get_ir(d)), 32'd1);

        // Unsigned all-ones with exact latency.
        set_in(0, 1'b1, fill(8, 17'h1FFFF), 4'h5);
        tick();
        set_in(0, 1'b0, '0, 4'h0);
        chk("t1_lat_e0", 32'(if0.out_valid), 32'd0);
        tick();
        chk("t1_lat_e1", 32'(if0.out_valid), 32'd0);
        tick();
        chk("t1_lat_e2", 32'(if0.out_valid), 32'd0);
        tick();
        chk("t1_lat_e3", 32'(if0.out_valid), 32'd1);
        chk("t1_sum", 32'(if0.out_sum), 32'h000FFFF8);
        chk("t1_tag", 32'(if0.out_tag), 32'h5);
        tick();

        // Signed: -1 x8 and most-negative x8.
        set_in(1, 1'b1, fill(8, 17'h1FFFF), 4'h1);
        tick();
        set_in(1, 1'b1, fill(8, 17'h10000), 4'h2);
        tick();
        set_in(1, 1'b0, '0, 4'h0);
        wait_out(1);
        chk("t2_sum_m8", 32'(if1.out_sum), 32'h000FFFF8);
        tick();
        chk("t2_valid_b2b", 32'(if1.out_valid), 32'd1);
        chk("t2_sum_min", 32'(if1.out_sum), 32'h00080000);
        chk("t2_tag_min", 32'(if1.out_tag), 32'h2);
        tick();

        // Back-to-back stream of ten tags.
        mark[0] = pops[0];
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1'b1, rand_vec(), i[3:0]);
            tick();
        end
        set_in(0, 1'b0, '0, 4'h0);
        repeat (6) tick();
        chk("t3_count", 32'(pops[0] - mark[0]), 32'd10);
        chk("t3_consecutive", 32'(last_pop[0] - first_pop[0] + 1), 32'd10);

        // Backpressure: fill the pipe, hold, then drain.
        mark[0] = pops[0];
        set_rdy(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b1, rand_vec(), 4'(8 + i));
            tick();
        end
        set_in(0, 1'b1, rand_vec(), 4'hC);
        chk("t4_in_ready_full", 32'(if0.in_ready), 32'd0);
        repeat (4) tick();
        chk("t4_in_ready_hold", 32'(if0.in_ready), 32'd0);
        chk("t4_out_held", 32'(if0.out_valid), 32'd1);
        set_rdy(0, 1'b1);
        begin
            int n = 0;
            acc_last[0] = 1'b0;
            while (!acc_last[0] && n < 10) begin
                tick();
                n++;
            end
            chk("t4_fifth_accepted", 32'(acc_last[0]), 32'd1);
        end
        set_in(0, 1'b0, '0, 4'h0);
        repeat (6) tick();
        chk("t4_delivered", 32'(pops[0] - mark[0]), 32'd5);
        chk("t4_drained", 32'(sbq[0].size()), 32'd0);

        // Flush with three in flight plus one accepted during the flush cycle.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1'b1, rand_vec(), i[3:0]);
            tick();
        end
        set_in(0, 1'b1, rand_vec(), 4'h3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(0, 1'b0, '0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t5_no_out_%0d", i), 32'(if0.out_valid), 32'd0);
            tick();
        end
        set_in(0, 1'b1, fill(8, 17'h00001), 4'hA);
        tick();
        set_in(0, 1'b0, '0, 4'h0);
        chk("t5_lat_e0", 32'(if0.out_valid), 32'd0);
        tick();
        tick();
        chk("t5_lat_e2", 32'(if0.out_valid), 32'd0);
        tick();
        chk("t5_lat_e3", 32'(if0.out_valid), 32'd1);
        chk("t5_sum", 32'(if0.out_sum), 32'd8);
        tick();

        // Asynchronous reset during a stall.
        set_rdy(0, 1'b0);
        set_rdy(2, 1'b0);
        set_in(0, 1'b1, fill(8, 17'h00010), 4'h1);
        set_in(2, 1'b1, fill(2, 17'h00020), 4'h2);
        tick();
        set_in(0, 1'b0, '0, 4'h0);
        set_in(2, 1'b0, '0, 4'h0);
        repeat (5) tick();
        chk("t6_stalled0", 32'(if0.out_valid), 32'd1);
        chk("t6_stalled2", 32'(if2.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid0", 32'(if0.out_valid), 32'd0);
        chk("t6_rst_sum0",   32'(if0.out_sum),   32'd0);
        chk("t6_rst_valid2", 32'(if2.out_valid), 32'd0);
        chk("t6_rst_sum2",   32'(if2.out_sum),   32'd0);
        for (int d = 0; d < 3; d++) sbq[d].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rdy(0, 1'b1);
        set_rdy(2, 1'b1);
        repeat (5) tick();
        chk("t6_post_rst0", 32'(if0.out_valid), 32'd0);
        chk("t6_post_rst2", 32'(if2.out_valid), 32'd0);
        set_in(2, 1'b1, {102'd0, 17'd4, 17'd3}, 4'h7);
        tick();
        set_in(2, 1'b0, '0, 4'h0);
        chk("t6_l1_lat_e0", 32'(if2.out_valid), 32'd0);
        tick();
        chk("t6_l1_lat_e1", 32'(if2.out_valid), 32'd1);
        chk("t6_l1_sum", 32'(if2.out_sum), 32'd7);
        chk("t6_l1_tag", 32'(if2.out_tag), 32'h7);
        repeat (2) tick();

        for (int d = 0; d < 3; d++) chk($sformatf("final_empty%0d", d), 32'(sbq[d].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
